// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA 800x600@60 constants and pixel-FIFO state encoding
package vga_pkg;

    localparam int H_ACTIVE = 800;
    localparam int V_ACTIVE = 600;
    localparam int H_TOTAL  = 1056;
    localparam int V_TOTAL  = 628;
    localparam int RGB_W    = 8;

    typedef enum logic {
        SYNC   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/vga_sync_fifo.sv
// rtl/vga_sync_fifo.sv - single-clock FIFO with wrapping pointers, level and registered full/empty
module vga_sync_fifo #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic [AW:0]  level,
    output logic         full,
    output logic         empty
);

    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic          r_full;
    logic [AW:0]   w_level_nxt;
    logic          w_wr;
    logic          w_rd;

    // Full is taken from the registered flag, so a same-cycle pop never frees a slot early
    assign w_wr = wr_en && !r_full;
    assign w_rd = rd_en && (r_level != '0);

    always_comb begin
        w_level_nxt = r_level;
        if (w_wr && !w_rd) begin
            w_level_nxt = r_level + 1'b1;
        end else if (!w_wr && w_rd) begin
            w_level_nxt = r_level - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == FULL_LVL);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    assign rd_data = r_mem[r_rptr];
    assign level   = r_level;
    assign full    = r_full;
    assign empty   = (r_level == '0);

endmodule

// File: rtl/vga_pixel_fifo.sv
// rtl/vga_pixel_fifo.sv - frame-aligned RGB332 pixel buffer feeding the VGA timing stage
// Optional VGA_PIXEL_FIFO_STATS_EN adds saturating underflow/resync counters.
module vga_pixel_fifo #(
    parameter int DEPTH     = 1024,
    parameter int AW        = 10,
    parameter int RGB_W     = 8,
    parameter int FRAME_PIX = vga_pkg::H_ACTIVE * vga_pkg::V_ACTIVE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [RGB_W-1:0] s_data,
    input  logic             s_sof,
    input  logic             disp_req,
    input  logic             disp_sof,
    output logic [RGB_W-1:0] disp_rgb,
    output logic             underflow,
    output logic             misalign,
    output logic             frame_done,
    output logic [AW:0]      level
`ifdef VGA_PIXEL_FIFO_STATS_EN
    ,
    output logic [15:0]      underflow_cnt,
    output logic [15:0]      resync_cnt
`endif
);

    import vga_pkg::*;

    localparam int CW = $clog2(FRAME_PIX + 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [RGB_W-1:0] r_rgb;
    logic             r_underflow;
    logic             r_misalign;
    logic             r_frame_done;
    logic             r_init;

    logic [RGB_W:0]   w_head;
    logic             w_head_sof;
    logic [RGB_W-1:0] w_head_data;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_to_sync;
    logic [CW-1:0]    w_cnt_inc;

    assign w_head_sof  = w_head[RGB_W];
    assign w_head_data = w_head[RGB_W-1:0];
    assign w_cnt_inc   = r_cnt + 1'b1;
    assign s_ready     = r_init && !w_full;

    vga_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (RGB_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (s_valid && s_ready),
        .wr_data ({s_sof, s_data}),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .level   (level),
        .full    (w_full),
        .empty   (w_empty)
    );

    // In SYNC, non-sof entries drain one per cycle until a frame start sits at the head
    always_comb begin
        w_pop = 1'b0;
        if (!w_empty) begin
            if (r_state == SYNC) begin
                w_pop = !w_head_sof || (disp_req && disp_sof);
            end else begin
                w_pop = disp_req && (w_head_sof == disp_sof);
            end
        end
    end

    assign w_to_sync = (r_state == STREAM) && disp_req && (w_empty || (w_head_sof != disp_sof));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= SYNC;
            r_cnt        <= '0;
            r_rgb        <= '0;
            r_underflow  <= 1'b0;
            r_misalign   <= 1'b0;
            r_frame_done <= 1'b0;
            r_init       <= 1'b0;
        end else begin
            r_init       <= 1'b1;
            r_underflow  <= 1'b0;
            r_misalign   <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                SYNC: begin
                    if (disp_req) begin
                        if (!w_empty && w_head_sof && disp_sof) begin
                            r_rgb   <= w_head_data;
                            r_cnt   <= CW'(1);
                            r_state <= STREAM;
                        end else begin
                            r_rgb <= '0;
                        end
                    end
                end
                STREAM: begin
                    if (disp_req) begin
                        if (w_empty) begin
                            r_rgb       <= '0;
                            r_underflow <= 1'b1;
                            r_state     <= SYNC;
                        end else if (w_head_sof != disp_sof) begin
                            r_rgb      <= '0;
                            r_misalign <= 1'b1;
                            r_state    <= SYNC;
                        end else begin
                            r_rgb <= w_head_data;
                            if (w_cnt_inc == CW'(FRAME_PIX)) begin
                                r_frame_done <= 1'b1;
                                r_cnt        <= '0;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign disp_rgb   = r_rgb;
    assign underflow  = r_underflow;
    assign misalign   = r_misalign;
    assign frame_done = r_frame_done;

`ifdef VGA_PIXEL_FIFO_STATS_EN
    logic [15:0] r_underflow_cnt;
    logic [15:0] r_resync_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underflow_cnt <= '0;
            r_resync_cnt    <= '0;
        end else begin
            if (w_to_sync && w_empty && (r_underflow_cnt != 16'hFFFF)) begin
                r_underflow_cnt <= r_underflow_cnt + 1'b1;
            end
            if (w_to_sync && (r_resync_cnt != 16'hFFFF)) begin
                r_resync_cnt <= r_resync_cnt + 1'b1;
            end
        end
    end

    assign underflow_cnt = r_underflow_cnt;
    assign resync_cnt    = r_resync_cnt;
`endif

endmodule
